// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing defaults, colour width and window decode helper.
package vga_timing_pkg;

  localparam int unsigned RGB_W = 12;
  localparam int unsigned CNT_W = 10;

  localparam int unsigned CLK_DIV_DEF        = 4;
  localparam int unsigned H_TOTAL_DEF        = 800;
  localparam int unsigned V_TOTAL_DEF        = 525;
  localparam int unsigned H_SYNC_DEF         = 96;
  localparam int unsigned V_SYNC_DEF         = 2;
  localparam int unsigned H_BRIGHT_START_DEF = 144;
  localparam int unsigned H_BRIGHT_END_DEF   = 784;
  localparam int unsigned V_BRIGHT_START_DEF = 35;
  localparam int unsigned V_BRIGHT_END_DEF   = 515;
  localparam int unsigned GAME_DIV_DEF       = 4;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Start inclusive, end exclusive on both axes.
  function automatic logic in_window(logic [CNT_W-1:0] h, logic [CNT_W-1:0] v,
                                     logic [CNT_W-1:0] hs, logic [CNT_W-1:0] he,
                                     logic [CNT_W-1:0] vs, logic [CNT_W-1:0] ve);
    return (h >= hs) && (h < he) && (v >= vs) && (v < ve);
  endfunction

endpackage

// File: rtl/clk_enable_div.sv
// Clock-enable divider: one-clk tick every DIV master clocks, counter 0..DIV-1.
module clk_enable_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // Gated by rst so a DIV of 1 still yields no tick while held in reset.
  assign tick = rst & (cnt_q == LAST);

endmodule

// File: rtl/display_timing_gen.sv
// VGA counters, sync, blanking and frame/game ticks. Define VGA_RGB_REG_EN to register
// the colour outputs on pix_tick (aligned with the syncs); default is combinational colour.
module display_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV        = CLK_DIV_DEF,
  parameter int unsigned H_TOTAL        = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL        = V_TOTAL_DEF,
  parameter int unsigned H_SYNC         = H_SYNC_DEF,
  parameter int unsigned V_SYNC         = V_SYNC_DEF,
  parameter int unsigned H_BRIGHT_START = H_BRIGHT_START_DEF,
  parameter int unsigned H_BRIGHT_END   = H_BRIGHT_END_DEF,
  parameter int unsigned V_BRIGHT_START = V_BRIGHT_START_DEF,
  parameter int unsigned V_BRIGHT_END   = V_BRIGHT_END_DEF,
  parameter int unsigned GAME_DIV       = GAME_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             bright,
  output logic             hSync,
  output logic             vSync,
  output logic [3:0]       vgaR,
  output logic [3:0]       vgaG,
  output logic [3:0]       vgaB,
  output logic             pix_tick,
  output logic             frame_tick,
  output logic             game_tick
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_W     = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_W     = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HB_START = CNT_W'(H_BRIGHT_START);
  localparam logic [CNT_W-1:0] HB_END   = CNT_W'(H_BRIGHT_END);
  localparam logic [CNT_W-1:0] VB_START = CNT_W'(V_BRIGHT_START);
  localparam logic [CNT_W-1:0] VB_END   = CNT_W'(V_BRIGHT_END);
  localparam logic [CNT_W-1:0] VB_LAST  = CNT_W'(V_BRIGHT_END - 1);
  localparam int unsigned      FW       = (GAME_DIV > 1) ? $clog2(GAME_DIV) : 1;
  localparam logic [FW-1:0]    F_LAST   = FW'(GAME_DIV - 1);

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             hsync_q, vsync_q;
  logic [FW-1:0]    frame_q, frame_d;
  logic [RGB_W-1:0] rgb_out;
  rgb_t             pix_out;

  clk_enable_div #(
    .DIV (CLK_DIV)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .tick (pix_tick)
  );

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  assign bright     = in_window(h_q, v_q, HB_START, HB_END, VB_START, VB_END);
  assign frame_tick = pix_tick && (h_q == H_LAST) && (v_q == VB_LAST);
  assign game_tick  = frame_tick && (frame_q == F_LAST);

  always_comb begin
    frame_d = frame_q;
    if (frame_tick) frame_d = (frame_q == F_LAST) ? '0 : frame_q + 1'b1;
  end

  // Syncs decode the post-tick counters so they change together with hCount/vCount.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      frame_q <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
      if (pix_tick) begin
        hsync_q <= (h_d >= HS_W);
        vsync_q <= (v_d >= VS_W);
      end
    end
  end

  assign hSync  = hsync_q;
  assign vSync  = vsync_q;
  assign hCount = h_q;
  assign vCount = v_q;

`ifdef VGA_RGB_REG_EN
  logic [RGB_W-1:0] rgb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          rgb_q <= '0;
    else if (pix_tick) rgb_q <= bright ? rgb_in : '0;
  end

  assign rgb_out = rgb_q;
`else
  assign rgb_out = bright ? rgb_in : '0;
`endif

  assign pix_out = rgb_out;
  assign vgaR    = pix_out.r;
  assign vgaG    = pix_out.g;
  assign vgaB    = pix_out.b;

endmodule

// File: tb/tb_display_timing_gen.sv
// Scoreboard bench for display_timing_gen with shrunk timing; expectations derived from
// elapsed clock count after reset release (pixel index arithmetic).
module tb_display_timing_gen;

  localparam int CD   = 2;
  localparam int HT   = 20;
  localparam int VT   = 12;
  localparam int HS   = 3;
  localparam int VS   = 2;
  localparam int HBS  = 5;
  localparam int HBE  = 17;
  localparam int VBS  = 2;
  localparam int VBE  = 10;
  localparam int GD   = 3;
  localparam int NCYC = 6000;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] rgb_in;
  logic [9:0]  hCount, vCount;
  logic        bright, hSync, vSync, pix_tick, frame_tick, game_tick;
  logic [3:0]  vgaR, vgaG, vgaB;

  display_timing_gen #(
    .CLK_DIV        (CD),
    .H_TOTAL        (HT),
    .V_TOTAL        (VT),
    .H_SYNC         (HS),
    .V_SYNC         (VS),
    .H_BRIGHT_START (HBS),
    .H_BRIGHT_END   (HBE),
    .V_BRIGHT_START (VBS),
    .V_BRIGHT_END   (VBE),
    .GAME_DIV       (GD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rgb_in     (rgb_in),
    .hCount     (hCount),
    .vCount     (vCount),
    .bright     (bright),
    .hSync      (hSync),
    .vSync      (vSync),
    .vgaR       (vgaR),
    .vgaG       (vgaG),
    .vgaB       (vgaB),
    .pix_tick   (pix_tick),
    .frame_tick (frame_tick),
    .game_tick  (game_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int v;
    int br;
    int hs;
    int vs;
    int pt;
    int ft;
    int gt;
    int rgb;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 0;

  function automatic int win(int h, int v);
    return (h >= HBS && h < HBE && v >= VBS && v < VBE) ? 1 : 0;
  endfunction

  // n = clk edges seen with rst high since release; p = pixels completed.
  function automatic exp_t model(int n, bit r, logic [11:0] rgb, logic [11:0] rgb_reg);
    exp_t e;
    int p, f, c;
    p    = n / CD;
    e.h  = p % HT;
    e.v  = (p / HT) % VT;
    e.br = win(e.h, e.v);
    e.pt = (r && (n % CD == CD - 1)) ? 1 : 0;
    e.hs = (p == 0) ? 1 : ((e.h >= HS) ? 1 : 0);
    e.vs = (p == 0) ? 1 : ((e.v >= VS) ? 1 : 0);
    e.ft = (e.pt == 1 && e.h == HT - 1 && e.v == VBE - 1) ? 1 : 0;
    c    = VBE * HT - 1;
    f    = (p > c) ? (p - 1 - c) / (HT * VT) + 1 : 0;
    e.gt = (e.ft == 1 && (f % GD) == GD - 1) ? 1 : 0;
`ifdef VGA_RGB_REG_EN
    e.rgb = int'(rgb_reg);
`else
    e.rgb = (e.br == 1) ? int'(rgb) : 0;
`endif
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Driver: advances the reference, randomizes colour and reset, pushes expectations.
  initial begin
    int          n;
    int          rst_at;
    int          rst_len;
    logic [11:0] rgb_reg;
    int          pp;
    n       = 0;
    rgb_reg = '0;
    rst     = 1'b0;
    rgb_in  = 12'hA5F;
    rst_at  = $urandom_range(2600, 2000);
    rst_len = $urandom_range(6, 2);
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (rst) begin
        n++;
        if (n % CD == 0) begin
          pp      = n / CD - 1;
          rgb_reg = (win(pp % HT, (pp / HT) % VT) == 1) ? rgb_in : 12'h000;
        end
      end
      if (cyc == 3) begin
        rst = 1'b1;
        n   = 0;
      end
      if (cyc == rst_at) begin
        rst     = 1'b0;
        n       = 0;
        rgb_reg = '0;
      end
      if (cyc == rst_at + rst_len) rst = 1'b1;
      rgb_in = ($urandom_range(1, 0) == 1) ? 12'hA5F : 12'($urandom);
      sb.push_back(model(n, rst, rgb_in, rgb_reg));
    end
    done = 1;
  end

  // Monitor: pops one expectation per clock and compares away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("hCount", int'(hCount), e.h);
        chk("vCount", int'(vCount), e.v);
        chk("bright", int'(bright), e.br);
        chk("hSync", int'(hSync), e.hs);
        chk("vSync", int'(vSync), e.vs);
        chk("pix_tick", int'(pix_tick), e.pt);
        chk("frame_tick", int'(frame_tick), e.ft);
        chk("game_tick", int'(game_tick), e.gt);
        chk("vga_rgb", int'({vgaR, vgaG, vgaB}), e.rgb);
      end else if (done) begin
        break;
      end else begin
        chk("scoreboard_underflow", 1, 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
